kdf_hash_arbiter: RTL

- Round-robin arbiter and sequencer that shares one hirose_present hash engine among NUM_REQ requesters, e.g. several KDF instances or a KDF plus a MAC unit.
- Latches the winning requester's 128-bit block and releases the engine's active-high reset to start it.
- Captures the digest on the engine's end pulse and returns it with a one-cycle ack to the winner.
- Sits between the requesters and a single hirose_present_wrapper instance.

---
 rtl/kdf_hash_arbiter.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/kdf_hash_arbiter.sv
// kdf_hash_arbiter
//   Round-robin arbiter and sequencer that lets NUM_REQ requesters share one
//   hirose_present hash engine. The winning requester's block is latched into
//   hash_plaintext. The engine is released from reset for the duration of the
//   job. The digest is captured on hash_end and returned with a one-cycle ack.
//
// Ports
//   clk, rst        system clock, asynchronous active-low reset
//   req             per-requester request level
//   req_data        per-requester block, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   ack             one-hot, one-cycle completion pulse to the served requester
//   resp_data       digest, valid with ack, held until the next completion
//   resp_id         index of the requester being served (or last served)
//   resp_err        watchdog timeout flag, coincident with ack
//   busy            high while a job is in RUN or DONE
//   hash_rst        active-high engine reset (1 = engine idle)
//   hash_plaintext  registered engine input block
//   hash_output     engine digest
//   hash_end        engine completion pulse
//   dbg_state       FSM state (0 IDLE, 1 RUN, 2 DONE)
//
// Handshake: a requester raises req with stable req_data and holds both until
//   its ack. It drops req in the cycle after ack; a req still high when IDLE is
//   re-entered is a new request and competes in round-robin order.
//
// Optional feature: define HASH_TIMEOUT_EN to add a RUN watchdog of
//   TIMEOUT_CYCLES cycles. Without it, RUN waits indefinitely and resp_err is 0.
module kdf_hash_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 128,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            ack,
  output logic [DATA_WIDTH-1:0]         resp_data,
  output logic [$clog2(NUM_REQ)-1:0]    resp_id,
  output logic                          resp_err,
  output logic                          busy,
  output logic                          hash_rst,
  output logic [DATA_WIDTH-1:0]         hash_plaintext,
  input  logic [DATA_WIDTH-1:0]         hash_output,
  input  logic                          hash_end,
  output logic [1:0]                    dbg_state
);

  localparam int IDW = $clog2(NUM_REQ);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("kdf_hash_arbiter: unsupported parameter set");
  end

  logic [1:0]            state_q, state_d;
  logic [IDW-1:0]        last_q, last_d;
  logic [IDW-1:0]        id_q, id_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] pt_q, pt_d;

`ifdef HASH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  // Per-requester view of the flat request bus.
  logic [DATA_WIDTH-1:0] slice [NUM_REQ];
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign slice[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Round-robin pick: first set req bit searching upward from last_q+1,
  // wrapping, so the last winner has lowest priority.
  logic           found;
  logic [IDW-1:0] win;
  logic [IDW-1:0] cand;

  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDW'((int'(last_q) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    data_d  = data_q;
    pt_d    = pt_q;
`ifdef HASH_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (found) begin
          pt_d    = slice[win];
          id_d    = win;
          state_d = S_RUN;
`ifdef HASH_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      S_RUN: begin
        // hash_end takes precedence over a watchdog expiry in the same cycle.
        if (hash_end) begin
          data_d  = hash_output;
          state_d = S_DONE;
`ifdef HASH_TIMEOUT_EN
          err_d   = 1'b0;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q + 1'b1;
`endif
        end
      end
      S_DONE: begin
        last_d  = id_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      last_q  <= IDW'(NUM_REQ - 1);
      id_q    <= '0;
      data_q  <= '0;
      pt_q    <= '0;
`ifdef HASH_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      data_q  <= data_d;
      pt_q    <= pt_d;
`ifdef HASH_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    ack = '0;
    if (state_q == S_DONE) ack[id_q] = 1'b1;
  end

  // hash_rst decodes straight from state so an asynchronous reset puts the
  // engine back into reset immediately.
  assign hash_rst       = (state_q != S_RUN);
  assign busy           = (state_q == S_RUN) || (state_q == S_DONE);
  assign resp_data      = data_q;
  assign resp_id        = id_q;
  assign hash_plaintext = pt_q;
  assign dbg_state      = state_q;

`ifdef HASH_TIMEOUT_EN
  assign resp_err = err_q & (state_q == S_DONE);
`else
  assign resp_err = 1'b0;
`endif

endmodule
